core_decode_unit: RTL
=====================

# core_decode_unit

Pipelined RV32I integer decode stage that produces the operation code and operands consumed by the core's combinational ALU. Accepts a fetched instruction and its PC over a valid/ready handshake, drives register-file read addresses, selects ALU operands (register, immediate, PC or zero) and registers the result into a one-entry pipeline stage toward execute. Covers OP, OP-IMM, LUI and AUIPC; everything else becomes a non-writing bubble or an illegal-instruction flag.

## Interface
- No module parameters; widths come from `REG_DATA_WIDTH` (32) and `ALU_OP_WIDTH` in `src/defines.vh`.
- One clock; reset is asynchronous and active-high.
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rs1_addr  out  5  register-file read address, in_instr[19:15], combinational
- rs2_addr  out  5  register-file read address, in_instr[24:20], combinational
- rs1_data  in  `REG_DATA_WIDTH`  register-file read data (asynchronous read)
- rs2_data  in  `REG_DATA_WIDTH`  register-file read data
- flush  in  1  discard stage contents (branch/trap redirect)
- out_valid  out  1  execute payload valid
- out_ready  in  1  execute accepts payload
- out_alu_op  out  `ALU_OP_WIDTH`  ALU operation, one of `ALU_OP_*`
- out_s1  out  `REG_DATA_WIDTH`  ALU operand 1
- out_s2  out  `REG_DATA_WIDTH`  ALU operand 2
- out_rd  out  5  destination register
- out_rd_we  out  1  writeback enable
- out_pc  out  32  PC of payload
- out_illegal  out  1  illegal instruction flag

## Operation
- Accept = in_valid && in_ready; in_ready = !flush && (!out_valid || out_ready).
- On accept: decode in_instr, capture rs1_data/rs2_data same cycle, load all out_* and set out_valid.
- No accept and out_ready: out_valid clears. Otherwise payload holds, bit-stable.
- flush: out_valid clears next edge regardless of out_ready; flush has priority over accept (in_ready low).
- OP (0110011): funct3/instr[30] select ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; s1=rs1_data, s2=rs2_data.
- OP-IMM (0010011): s2 = sign-extended I-immediate; funct3 000 -> ADD (instr[30] ignored); 101 -> SRL/SRA via instr[30]; shifts pass the immediate unmodified (ALU uses s2[4:0]).
- LUI (0110111): ADD, s1=0, s2={instr[31:12],12'b0}. AUIPC (0010111): ADD, s1=in_pc, s2=U-immediate.
- out_rd = instr[11:7]; out_rd_we = 1 for the four classes above, forced 0 when rd = 0.
- Other opcodes: ALU_OP_ADD, s1=s2=0, out_rd_we=0.

## Timing
- Latency: one cycle accept-to-out_valid; full throughput (one instruction per cycle) when out_ready held high.
- rs*_addr follow in_instr combinationally; no registered read path.
- Reset (asynchronous, any cycle including mid-stall): out_valid=0, out_alu_op=`ALU_OP_ADD`, out_s1/s2/pc=0, out_rd=0, out_rd_we=0, out_illegal=0; in_ready=1 the cycle after release.

## Configuration
- `CORE_DECODE_ILLEGAL_EN` defined: out_illegal=1 (with out_rd_we=0, ALU_OP_ADD) for instr[1:0]!=2'b11, unsupported opcode, OP funct7 not 0000000/0100000, 0100000 with funct3 not 000/101, OP-IMM shift with bad funct7.
- Not defined: out_illegal tied 0; unsupported opcodes decode as bubbles; only instr[30] of funct7 inspected.

## Structure
- Opcode constants (`OPCODE_OP`, `OPCODE_OP_IMM`, `OPCODE_LUI`, `OPCODE_AUIPC`) and funct3 values added to `src/defines.vh` beside `ALU_OP_*`.
- One combinational sub-module: `core_decode_unit_immgen` (I- and U-immediate formation).

## Test plan
- 0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=7 -> next cycle out_valid=1, ALU_OP_ADD, s1=5, s2=7, rd=3, rd_we=1; 0x402081B3 -> ALU_OP_SUB.
- 0xFFF00093 (addi x1,x0,-1), rs1_data=0 -> ALU_OP_ADD, s2=0xFFFFFFFF, rd=1; 0x40435293 (srai x5,x6,4) -> ALU_OP_SRA, s2[4:0]=4.
- 0x12345537 (lui x10) -> s1=0, s2=0x12345000; auipc x10 with in_pc=0x100 -> s1=0x100, same s2.
- out_ready=0 for 3 cycles with in_valid high -> in_ready=0, payload unchanged; flush while stalled -> out_valid=0 next cycle, no instruction lost beyond the flushed one.
- 0x0000000B -> with macro out_illegal=1, rd_we=0; without macro out_illegal=0, rd_we=0; add with rd=x0 -> rd_we=0.
- rst asserted mid-stream between edges -> all outputs at reset values immediately, no payload emitted after release until new accept.

Source files
------------

// File: rtl/core_decode_unit_pkg.sv
// Shared constants, payload type and funct3-to-ALU mapping for the RV32I decode stage.
// ALU operation codes sit beside the opcode and funct3/funct7 constants they are derived from.
package core_decode_unit_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int ALU_OP_WIDTH   = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd9;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0]   alu_op;
        logic [REG_DATA_WIDTH-1:0] s1;
        logic [REG_DATA_WIDTH-1:0] s2;
        logic [4:0]                rd;
        logic                      rd_we;
        logic [31:0]               pc;
        logic                      illegal;
    } payload_t;

    localparam payload_t PAYLOAD_RESET = '{
        alu_op:  ALU_OP_ADD,
        s1:      '0,
        s2:      '0,
        rd:      5'd0,
        rd_we:   1'b0,
        pc:      32'd0,
        illegal: 1'b0
    };

    // alt selects SUB/SRA; callers decide when instr[30] is meaningful.
    function automatic logic [ALU_OP_WIDTH-1:0] alu_op_from_funct3(
        input logic [2:0] funct3,
        input logic       alt
    );
        logic [ALU_OP_WIDTH-1:0] op;
        case (funct3)
            FUNCT3_ADD_SUB: op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            FUNCT3_SLL:     op = ALU_OP_SLL;
            FUNCT3_SLT:     op = ALU_OP_SLT;
            FUNCT3_SLTU:    op = ALU_OP_SLTU;
            FUNCT3_XOR:     op = ALU_OP_XOR;
            FUNCT3_SRL_SRA: op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            FUNCT3_OR:      op = ALU_OP_OR;
            default:        op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/core_decode_unit_if.sv
// Fetch, register-file and execute signals of the decode stage.
// master is the decode unit's view; slave is the surrounding pipeline's view.
import core_decode_unit_pkg::*;

interface core_decode_unit_if;
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_instr;
    logic [31:0]               in_pc;
    logic [4:0]                rs1_addr;
    logic [4:0]                rs2_addr;
    logic [REG_DATA_WIDTH-1:0] rs1_data;
    logic [REG_DATA_WIDTH-1:0] rs2_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [ALU_OP_WIDTH-1:0]   out_alu_op;
    logic [REG_DATA_WIDTH-1:0] out_s1;
    logic [REG_DATA_WIDTH-1:0] out_s2;
    logic [4:0]                out_rd;
    logic                      out_rd_we;
    logic [31:0]               out_pc;
    logic                      out_illegal;

    modport master (
        input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, out_alu_op, out_s1, out_s2,
               out_rd, out_rd_we, out_pc, out_illegal
    );

    modport slave (
        output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, out_alu_op, out_s1, out_s2,
               out_rd, out_rd_we, out_pc, out_illegal
    );
endinterface

// File: rtl/core_decode_unit_immgen.sv
// Combinational I- and U-immediate formation from instr[31:12].
module core_decode_unit_immgen (
    input  logic [19:0] instr_upper,
    output logic [31:0] imm_i,
    output logic [31:0] imm_u
);
    assign imm_i[10:0] = instr_upper[18:8];

    genvar gi;
    generate
        for (gi = 11; gi < 32; gi++) begin : g_sign
            assign imm_i[gi] = instr_upper[19];
        end
    endgenerate

    assign imm_u = {instr_upper, 12'h000};
endmodule

// File: rtl/core_decode_unit.sv
// RV32I decode stage (OP, OP-IMM, LUI, AUIPC) with a one-entry registered payload toward execute.
// Define CORE_DECODE_ILLEGAL_EN to enable funct7/opcode legality checks and the out_illegal flag.
module core_decode_unit
    import core_decode_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    core_decode_unit_if.master bus
);

`ifdef CORE_DECODE_ILLEGAL_EN
    localparam logic ILLEGAL_EN = 1'b1;
`else
    localparam logic ILLEGAL_EN = 1'b0;
`endif

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        op_f7_ok;
    logic        imm_f7_ok;
    logic        accept;

    payload_t    payload_reg;
    payload_t    dec_next;
    logic        valid_reg;
    logic        dec_writes;
    logic        dec_bad;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];

    assign bus.rs1_addr = instr[19:15];
    assign bus.rs2_addr = instr[24:20];

    core_decode_unit_immgen u_immgen (
        .instr_upper (instr[31:12]),
        .imm_i       (imm_i),
        .imm_u       (imm_u)
    );

    // With checks disabled every funct7 is accepted and only instr[30] steers SUB/SRA.
    assign op_f7_ok = !ILLEGAL_EN
                   || (funct7 == FUNCT7_BASE)
                   || ((funct7 == FUNCT7_ALT)
                       && ((funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SRL_SRA)));

    assign imm_f7_ok = !ILLEGAL_EN
                    || ((funct3 == FUNCT3_SLL) ? (funct7 == FUNCT7_BASE) :
                        (funct3 == FUNCT3_SRL_SRA) ? ((funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT)) :
                        1'b1);

    always_comb begin
        dec_next    = PAYLOAD_RESET;
        dec_next.rd = rd;
        dec_next.pc = bus.in_pc;
        dec_writes  = 1'b0;
        dec_bad     = 1'b0;
        case (opcode)
            OPCODE_OP: begin
                if (op_f7_ok) begin
                    dec_next.alu_op = alu_op_from_funct3(funct3, instr[30]);
                    dec_next.s1     = bus.rs1_data;
                    dec_next.s2     = bus.rs2_data;
                    dec_writes      = 1'b1;
                end else begin
                    dec_bad = 1'b1;
                end
            end
            OPCODE_OP_IMM: begin
                // instr[30] is part of the immediate for ADDI, so it only matters for SRLI/SRAI.
                if (imm_f7_ok) begin
                    dec_next.alu_op = alu_op_from_funct3(funct3,
                                          (funct3 == FUNCT3_SRL_SRA) && instr[30]);
                    dec_next.s1     = bus.rs1_data;
                    dec_next.s2     = imm_i;
                    dec_writes      = 1'b1;
                end else begin
                    dec_bad = 1'b1;
                end
            end
            OPCODE_LUI: begin
                dec_next.s2 = imm_u;
                dec_writes  = 1'b1;
            end
            OPCODE_AUIPC: begin
                dec_next.s1 = bus.in_pc;
                dec_next.s2 = imm_u;
                dec_writes  = 1'b1;
            end
            default: dec_bad = 1'b1;
        endcase
        dec_next.rd_we   = dec_writes && (rd != 5'd0);
        dec_next.illegal = ILLEGAL_EN && dec_bad;
    end

    assign bus.in_ready = !bus.flush && (!valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Payload is left untouched when the stage drains or flushes so it stays bit-stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            payload_reg <= PAYLOAD_RESET;
        end else if (accept) begin
            valid_reg   <= 1'b1;
            payload_reg <= dec_next;
        end else if (bus.flush || bus.out_ready) begin
            valid_reg   <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_reg;
    assign bus.out_alu_op  = payload_reg.alu_op;
    assign bus.out_s1      = payload_reg.s1;
    assign bus.out_s2      = payload_reg.s2;
    assign bus.out_rd      = payload_reg.rd;
    assign bus.out_rd_we   = payload_reg.rd_we;
    assign bus.out_pc      = payload_reg.pc;
    assign bus.out_illegal = payload_reg.illegal;

endmodule
